// File: rtl/systolic_ctrl.sv
// Sequencer for a ROWS x COLS systolic array: runs one pass of inner length K,
// issuing skewed operand feed enables and a diagonal wavefront of PE enables.
module systolic_ctrl #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int K_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [K_W-1:0]       k_len,
   input  logic                 abort,
   output logic [ROWS*COLS-1:0] op,
   output logic [ROWS-1:0]      a_en,
   output logic [COLS-1:0]      b_en,
   output logic                 busy,
   output logic                 done
);

   // state | meaning
   // IDLE  | waiting for start; done may pulse here for one cycle
   // RUN   | cnt walks 0 .. K+ROWS+COLS-3 driving the wavefront

   // Counter must reach Kmax+ROWS+COLS-3 and also hold i+j+K for the compares.
   localparam int CW = $clog2((2**K_W) + ROWS + COLS);

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic [K_W-1:0] k_reg, k_nxt;
   logic           done_nxt;
   logic [CW-1:0]  k_ext;
   logic [CW-1:0]  last_cnt;

   assign k_ext    = CW'(k_reg);
   // K >= 1 whenever in RUN, so the subtraction never underflows there.
   assign last_cnt = k_ext + CW'(ROWS + COLS - 2) - CW'(1);

   // State, counter, latched K and registered done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         k_reg <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         k_reg <= k_nxt;
         done  <= done_nxt;
      end
   end

   // Next-state: start accepted only in IDLE; abort beats final count.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      k_nxt     = k_reg;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (k_len != '0) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
                  k_nxt     = k_len;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == last_cnt) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Enable decode from registered state/cnt only: window [offset, offset+K-1].
   always_comb begin
      op   = '0;
      a_en = '0;
      b_en = '0;
      busy = (state == RUN);
      if (state == RUN) begin
         for (int i = 0; i < ROWS; i++) begin
            a_en[i] = (cnt >= CW'(i)) && (cnt < CW'(i) + k_ext);
            for (int j = 0; j < COLS; j++) begin
               op[i*COLS+j] = (cnt >= CW'(i + j)) && (cnt < CW'(i + j) + k_ext);
            end
         end
         for (int j = 0; j < COLS; j++) begin
            b_en[j] = (cnt >= CW'(j)) && (cnt < CW'(j) + k_ext);
         end
      end
   end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: a 2x2 and a 4x4 instance. Stimulus pushes
// hand-computed per-cycle output records; monitors pop one whenever busy or done
// is high and require all enables quiet otherwise.
module tb_systolic_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start2, abort2, start4, abort4;
   logic [7:0]  k2, k4;
   logic [3:0]  op2;
   logic [1:0]  a2, b2;
   logic        busy2, done2;
   logic [15:0] op4;
   logic [3:0]  a4, b4;
   logic        busy4, done4;

   int checks   = 0;
   int failures = 0;
   logic mon_on = 1'b0;

   // record layout: {busy, done, a_en, b_en, op}
   logic [9:0]  q2[$];
   logic [25:0] q4[$];

   always #5 clk = ~clk;

   systolic_ctrl #(.ROWS(2), .COLS(2), .K_W(8)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .k_len(k2), .abort(abort2),
      .op(op2), .a_en(a2), .b_en(b2), .busy(busy2), .done(done2));

   systolic_ctrl #(.ROWS(4), .COLS(4), .K_W(8)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .k_len(k4), .abort(abort4),
      .op(op4), .a_en(a4), .b_en(b4), .busy(busy4), .done(done4));

   // 2x2 monitor
   always @(negedge clk) begin
      if (mon_on) begin
         checks++;
         if (busy2 || done2) begin
            if (q2.size() == 0) begin
               failures++;
               $display("FAIL unexpected_out2 got busy=%b done=%b op=%b a=%b b=%b required no output",
                        busy2, done2, op2, a2, b2);
            end else begin
               logic [9:0] e;
               e = q2.pop_front();
               if ({busy2, done2, a2, b2, op2} !== e) begin
                  failures++;
                  $display("FAIL rec2 got %b required %b (busy,done,a,b,op) t=%0t",
                           {busy2, done2, a2, b2, op2}, e, $time);
               end
            end
         end else if ({op2, a2, b2} !== '0) begin
            failures++;
            $display("FAIL quiet2 got op=%b a=%b b=%b required all 0", op2, a2, b2);
         end
      end
   end

   // 4x4 monitor
   always @(negedge clk) begin
      if (mon_on) begin
         checks++;
         if (busy4 || done4) begin
            if (q4.size() == 0) begin
               failures++;
               $display("FAIL unexpected_out4 got busy=%b done=%b op=%h required no output",
                        busy4, done4, op4);
            end else begin
               logic [25:0] e;
               e = q4.pop_front();
               if ({busy4, done4, a4, b4, op4} !== e) begin
                  failures++;
                  $display("FAIL rec4 got %h required %h (busy,done,a,b,op) t=%0t",
                           {busy4, done4, a4, b4, op4}, e, $time);
               end
            end
         end else if ({op4, a4, b4} !== '0) begin
            failures++;
            $display("FAIL quiet4 got op=%h a=%b b=%b required all 0", op4, a4, b4);
         end
      end
   end

   task automatic push2(input logic bz, input logic dn, input logic [1:0] a,
                        input logic [1:0] b, input logic [3:0] o);
      q2.push_back({bz, dn, a, b, o});
   endtask

   task automatic push4(input logic bz, input logic dn, input logic [3:0] a,
                        input logic [3:0] b, input logic [15:0] o);
      q4.push_back({bz, dn, a, b, o});
   endtask

   // 2x2, K=3: five RUN cycles then done
   task automatic exp2_k3(input logic with_done);
      push2(1, 0, 2'b01, 2'b01, 4'b0001);
      push2(1, 0, 2'b11, 2'b11, 4'b0111);
      push2(1, 0, 2'b11, 2'b11, 4'b1111);
      push2(1, 0, 2'b10, 2'b10, 4'b1110);
      push2(1, 0, 2'b00, 2'b00, 4'b1000);
      if (with_done) push2(0, 1, 2'b00, 2'b00, 4'b0000);
   endtask

   // 2x2, K=2: four RUN cycles then done
   task automatic exp2_k2();
      push2(1, 0, 2'b01, 2'b01, 4'b0001);
      push2(1, 0, 2'b11, 2'b11, 4'b0111);
      push2(1, 0, 2'b10, 2'b10, 4'b1110);
      push2(1, 0, 2'b00, 2'b00, 4'b1000);
      push2(0, 1, 2'b00, 2'b00, 4'b0000);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start2 = 0; abort2 = 0; start4 = 0; abort4 = 0;
      k2 = 8'd0; k4 = 8'd0;
      tick(3);
      rst = 1'b0;
      mon_on = 1'b1;
      tick(2);

      // Basic 2x2 K=3 pass; k_len and start wiggled mid-run must not matter.
      exp2_k3(1'b1);
      start2 = 1; k2 = 8'd3;
      tick(1);
      start2 = 0; k2 = 8'd1;
      tick(1);
      start2 = 1; k2 = 8'd0;
      tick(1);
      start2 = 0;
      tick(6);

      // Abort while idle: nothing happens.
      abort2 = 1;
      tick(2);
      abort2 = 0;
      tick(2);

      // 4x4 K=1: single-cycle diagonal wavefront over 7 cycles.
      push4(1, 0, 4'b0001, 4'b0001, 16'h0001);
      push4(1, 0, 4'b0010, 4'b0010, 16'h0012);
      push4(1, 0, 4'b0100, 4'b0100, 16'h0124);
      push4(1, 0, 4'b1000, 4'b1000, 16'h1248);
      push4(1, 0, 4'b0000, 4'b0000, 16'h2480);
      push4(1, 0, 4'b0000, 4'b0000, 16'h4800);
      push4(1, 0, 4'b0000, 4'b0000, 16'h8000);
      push4(0, 1, 4'b0000, 4'b0000, 16'h0000);
      start4 = 1; k4 = 8'd1;
      tick(1);
      start4 = 0;
      tick(10);

      // k_len=0: done only, no busy.
      push2(0, 1, 2'b00, 2'b00, 4'b0000);
      push4(0, 1, 4'b0000, 4'b0000, 16'h0000);
      start2 = 1; k2 = 8'd0; start4 = 1; k4 = 8'd0;
      tick(1);
      start2 = 0; start4 = 0;
      tick(3);

      // Abort at cnt=2 (first three RUN records only), then a full pass.
      push2(1, 0, 2'b01, 2'b01, 4'b0001);
      push2(1, 0, 2'b11, 2'b11, 4'b0111);
      push2(1, 0, 2'b11, 2'b11, 4'b1111);
      start2 = 1; k2 = 8'd3;
      tick(1);
      start2 = 0;
      tick(2);
      abort2 = 1;
      tick(1);
      abort2 = 0;
      tick(1);
      exp2_k3(1'b1);
      start2 = 1;
      tick(1);
      start2 = 0;
      tick(7);

      // Abort on the final count: abort wins, no done.
      exp2_k3(1'b0);
      start2 = 1;
      tick(1);
      start2 = 0;
      tick(4);
      abort2 = 1;
      tick(1);
      abort2 = 0;
      tick(3);

      // Back-to-back with start held: three K=2 passes, 5-cycle period.
      exp2_k2();
      exp2_k2();
      exp2_k2();
      start2 = 1; k2 = 8'd2;
      tick(11);
      start2 = 0;
      tick(8);

      // Reset at cnt=1: outputs drop, no done for 10 cycles.
      push2(1, 0, 2'b01, 2'b01, 4'b0001);
      push2(1, 0, 2'b11, 2'b11, 4'b0111);
      start2 = 1; k2 = 8'd3;
      tick(1);
      start2 = 0;
      tick(1);
      rst = 1; start2 = 1; abort2 = 1;
      tick(1);
      rst = 0; start2 = 0; abort2 = 0;
      tick(10);

      mon_on = 1'b0;
      checks++;
      if (q2.size() != 0) begin
         failures++;
         $display("FAIL drain2 got %0d records left required 0", q2.size());
      end
      checks++;
      if (q4.size() != 0) begin
         failures++;
         $display("FAIL drain4 got %0d records left required 0", q4.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
